seq_alu: RTL and testbench

Parametrised, multi-cycle successor to the single-cycle datapath ALU. Accepts one operation at a time over a valid/ready handshake, applies the same condition-code and shift/rotate pre-processing, and returns a registered result. Holds the architectural NZCV flags register internally. Multiplication runs on an iterative shift-add unit, so the core can be closed at higher clock rates in WIDTH-generic builds.

---
 rtl/seq_alu_if.sv | 31 +++
 rtl/seq_alu.sv | 212 +++++++++++++++++++++
 tb/tb_seq_alu.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_alu_if.sv
// Request/response bundle for seq_alu: operation request (valid/ready),
// result return (valid/ready) and the status outputs that qualify the result.
interface seq_alu_if #(
    parameter int WIDTH = 32,
    parameter int IMM_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       opcode;
    logic [3:0]       cond;
    logic [2:0]       srcontrol;
    logic             sbit;
    logic [IMM_W-1:0] imvalue;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [3:0]       flags;
    logic             skipped;

    modport master (
        output in_valid, opcode, cond, srcontrol, sbit, imvalue, in1, in2, out_ready,
        input  in_ready, out_valid, result, flags, skipped
    );

    modport slave (
        input  in_valid, opcode, cond, srcontrol, sbit, imvalue, in1, in2, out_ready,
        output in_ready, out_valid, result, flags, skipped
    );
endinterface

// File: rtl/seq_alu.sv
// Multi-cycle conditional ALU with internal NZCV register and iterative shift-add multiplier.
// Define SEQ_ALU_MUL_EN to build the multiplier; otherwise opcode 2 executes as a NOP.
module seq_alu #(
    parameter int WIDTH = 32,
    parameter int IMM_W = 16
) (
    input logic      clk,
    input logic      reset,
    seq_alu_if.slave bus
);
    localparam int SH_W = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

    typedef enum logic [3:0] {
        OP_ADD    = 4'd0,
        OP_SUB    = 4'd1,
        OP_MUL    = 4'd2,
        OP_OR     = 4'd3,
        OP_AND    = 4'd4,
        OP_XOR    = 4'd5,
        OP_MOVN   = 4'd6,
        OP_MOVREG = 4'd7,
        OP_CMP    = 4'd8
    } op_t;

    state_t           r_state;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_skipped;
    logic [WIDTH-1:0] r_result;
    logic [3:0]       r_flags;

    logic [SH_W-1:0]  w_amt;
    logic [SH_W-1:0]  w_ramt;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH-1:0] w_imm_ext;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_res;
    logic [WIDTH-1:0] w_fsrc;
    logic [3:0]       w_flags_next;
    logic             w_cond_ok;
    logic             w_c;
    logic             w_v;
    logic             w_upd;
    logic             w_is_cmp;
    logic             w_n_f;
    logic             w_z_f;
    logic             w_c_f;
    logic             w_v_f;

    assign {w_n_f, w_z_f, w_c_f, w_v_f} = r_flags;

    generate
        if (IMM_W >= WIDTH) begin : g_imm_trunc
            assign w_imm_ext = bus.imvalue[WIDTH-1:0];
        end else begin : g_imm_zext
            assign w_imm_ext = {{(WIDTH-IMM_W){1'b0}}, bus.imvalue};
        end
    endgenerate

    // Rotate uses the complementary amount modulo WIDTH, so amount 0 degenerates to in2.
    assign w_amt  = bus.imvalue[SH_W+2:3];
    assign w_ramt = SH_W'(0) - w_amt;
    assign w_sum  = {1'b0, bus.in1} + {1'b0, w_b};
    assign w_diff = {1'b0, bus.in1} - {1'b0, w_b};

    // NOTE: every signal gets a default at the top of always_comb, so no path can infer a latch.
    always_comb begin
        w_b       = bus.in2;
        w_cond_ok = 1'b1;
        w_res     = '0;
        w_c       = w_c_f;
        w_v       = w_v_f;
        w_upd     = 1'b0;
        w_is_cmp  = 1'b0;

        case (bus.srcontrol)
            3'b001:  w_b = bus.in2 >> w_amt;
            3'b010:  w_b = bus.in2 << w_amt;
            3'b011:  w_b = (bus.in2 >> w_amt) | (bus.in2 << w_ramt);
            default: w_b = bus.in2;
        endcase

        case (bus.cond)
            4'd1:    w_cond_ok = w_z_f;
            4'd2:    w_cond_ok = !w_z_f && (w_n_f == w_v_f);
            4'd3:    w_cond_ok = !w_z_f && (w_n_f != w_v_f);
            4'd4:    w_cond_ok = (w_n_f == w_v_f);
            4'd5:    w_cond_ok = (w_n_f != w_v_f);
            4'd6:    w_cond_ok = !w_z_f && w_c_f;
            4'd7:    w_cond_ok = !w_c_f;
            4'd8:    w_cond_ok = w_c_f;
            default: w_cond_ok = 1'b1;
        endcase

        if (w_cond_ok) begin
            case (op_t'(bus.opcode))
                OP_ADD: begin
                    w_res = w_sum[WIDTH-1:0];
                    w_c   = w_sum[WIDTH];
                    w_v   = (bus.in1[WIDTH-1] == w_b[WIDTH-1]) && (w_sum[WIDTH-1] != bus.in1[WIDTH-1]);
                    w_upd = bus.sbit;
                end
                OP_SUB, OP_CMP: begin
                    w_res    = (bus.opcode == OP_SUB) ? w_diff[WIDTH-1:0] : '0;
                    w_c      = ~w_diff[WIDTH];
                    w_v      = (bus.in1[WIDTH-1] != w_b[WIDTH-1]) && (w_diff[WIDTH-1] != bus.in1[WIDTH-1]);
                    w_is_cmp = (bus.opcode == OP_CMP);
                    w_upd    = bus.sbit || w_is_cmp;
                end
                OP_OR:     begin w_res = bus.in1 | w_b; w_upd = bus.sbit; end
                OP_AND:    begin w_res = bus.in1 & w_b; w_upd = bus.sbit; end
                OP_XOR:    begin w_res = bus.in1 ^ w_b; w_upd = bus.sbit; end
                OP_MOVN:   begin w_res = w_imm_ext;     w_upd = bus.sbit; end
                OP_MOVREG: begin w_res = bus.in1;       w_upd = bus.sbit; end
                default:   w_res = '0;
            endcase
        end

        w_fsrc       = w_is_cmp ? w_diff[WIDTH-1:0] : w_res;
        w_flags_next = {w_fsrc[WIDTH-1], (w_fsrc == '0), w_c, w_v};
    end

`ifdef SEQ_ALU_MUL_EN
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] r_acc;
    logic [SH_W-1:0]  r_cnt;
    logic             r_sbit;
    logic [WIDTH-1:0] w_acc_next;
    logic             w_is_mul;

    assign w_is_mul   = w_cond_ok && (bus.opcode == OP_MUL);
    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
`endif

    // NOTE: every register here uses <= so all state updates see pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_flags     <= 4'b0000;
            r_skipped   <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_sbit      <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_in_ready <= 1'b1;
                    if (bus.in_valid && r_in_ready) begin
                        r_in_ready <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
                        if (w_is_mul) begin
                            r_state   <= S_MUL;
                            r_mcand   <= bus.in1;
                            r_mplier  <= w_b;
                            r_acc     <= '0;
                            r_cnt     <= '0;
                            r_sbit    <= bus.sbit;
                            r_skipped <= 1'b0;
                        end else
`endif
                        begin
                            r_state     <= S_DONE;
                            r_out_valid <= 1'b1;
                            r_result    <= w_res;
                            r_skipped   <= ~w_cond_ok;
                            if (w_upd) r_flags <= w_flags_next;
                        end
                    end
                end
`ifdef SEQ_ALU_MUL_EN
                S_MUL: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + SH_W'(1);
                    if (r_cnt == SH_W'(WIDTH - 1)) begin
                        r_state     <= S_DONE;
                        r_out_valid <= 1'b1;
                        r_result    <= w_acc_next;
                        if (r_sbit) r_flags <= {w_acc_next[WIDTH-1], (w_acc_next == '0), 2'b00};
                    end
                end
`endif
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.result    = r_result;
    assign bus.flags     = r_flags;
    assign bus.skipped   = r_skipped;
endmodule

// File: tb/tb_seq_alu.sv
// Randomised bench for seq_alu against an arithmetic reference model of the ALU rules;
// expectations follow SEQ_ALU_MUL_EN when it is defined for the build.
module tb_seq_alu;
`ifdef SEQ_ALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif
    localparam longint unsigned MASK = 64'hFFFF_FFFF;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  fl;
        logic        skip;
        int          lat;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;
    logic [3:0] m_flags;

    seq_alu_if #(.WIDTH(32), .IMM_W(16)) bus ();

    seq_alu #(.WIDTH(32), .IMM_W(16)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [3:0] op, input logic [3:0] cnd, input logic [2:0] sr,
                                   input logic sb, input logic [15:0] imm, input logic [31:0] a,
                                   input logic [31:0] bin, input logic [3:0] fl);
        exp_t e;
        logic n, z, c, v, ok, upd;
        longint unsigned ua, ub, bl, full;
        longint sa, sbv, sres;
        logic [31:0] fsrc, bw;
        int amt;
        {n, z, c, v} = fl;
        case (cnd)
            4'd1: ok = z;
            4'd2: ok = !z && (n == v);
            4'd3: ok = !z && (n != v);
            4'd4: ok = (n == v);
            4'd5: ok = (n != v);
            4'd6: ok = !z && c;
            4'd7: ok = !c;
            4'd8: ok = c;
            default: ok = 1'b1;
        endcase
        amt = int'(imm >> 3) & 31;
        ua = longint'(a);
        bl = longint'(bin);
        case (sr)
            3'd1: ub = bl >> amt;
            3'd2: ub = (bl << amt) & MASK;
            3'd3: ub = ((bl >> amt) | (bl << (32 - amt))) & MASK;
            default: ub = bl;
        endcase
        bw  = ub[31:0];
        sa  = longint'($signed(a));
        sbv = longint'($signed(bw));
        e.res = 32'h0; e.fl = fl; e.skip = !ok; e.lat = 1;
        upd = 1'b0; fsrc = 32'h0;
        if (ok) begin
            case (op)
                4'd0: begin
                    full = ua + ub; e.res = full[31:0]; c = full[32];
                    sres = sa + sbv; v = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
                    upd = sb; fsrc = e.res;
                end
                4'd1, 4'd8: begin
                    full = ua - ub; c = (ua >= ub);
                    sres = sa - sbv; v = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
                    fsrc = full[31:0];
                    e.res = (op == 4'd1) ? full[31:0] : 32'h0;
                    upd = sb || (op == 4'd8);
                end
                4'd2: if (MUL_EN) begin
                    full = ua * ub; e.res = full[31:0]; c = 1'b0; v = 1'b0;
                    upd = sb; fsrc = e.res; e.lat = 33;
                end
                4'd3: begin e.res = a | bw; upd = sb; fsrc = e.res; end
                4'd4: begin e.res = a & bw; upd = sb; fsrc = e.res; end
                4'd5: begin e.res = a ^ bw; upd = sb; fsrc = e.res; end
                4'd6: begin e.res = {16'h0, imm}; upd = sb; fsrc = e.res; end
                4'd7: begin e.res = a; upd = sb; fsrc = e.res; end
                default: e.res = 32'h0;
            endcase
        end
        if (upd) e.fl = {fsrc[31], (fsrc == 32'h0), c, v};
        return e;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic drive_junk(input logic vld);
        bus.in_valid  = vld;
        bus.opcode    = 4'($urandom_range(0, 15));
        bus.cond      = 4'($urandom_range(0, 15));
        bus.srcontrol = 3'($urandom_range(0, 7));
        bus.sbit      = 1'($urandom_range(0, 1));
        bus.imvalue   = 16'($urandom);
        bus.in1       = $urandom;
        bus.in2       = $urandom;
    endtask

    // Issues one operation from a negedge, checks latency and outputs, then retires it.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [3:0] cnd,
                          input logic [2:0] sr, input logic sb, input logic [15:0] imm,
                          input logic [31:0] a, input logic [31:0] b, input int hold,
                          output logic [31:0] o_res, output logic [3:0] o_fl, output logic o_skip);
        exp_t e;
        int lat;
        int w;
        w = 0;
        while (!bus.in_ready && w < 50) begin @(negedge clk); w++; end
        check({tag, "_accept_ready"}, 64'(bus.in_ready), 64'd1);
        e = model(op, cnd, sr, sb, imm, a, b, m_flags);
        bus.in_valid = 1'b1; bus.opcode = op; bus.cond = cnd; bus.srcontrol = sr;
        bus.sbit = sb; bus.imvalue = imm; bus.in1 = a; bus.in2 = b;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        drive_junk(1'b1);
        while (!bus.out_valid && lat < 100) begin
            @(posedge clk); lat++; @(negedge clk);
        end
        check({tag, "_latency"}, 64'(lat), 64'(e.lat));
        check({tag, "_result"}, 64'(bus.result), 64'(e.res));
        check({tag, "_flags"}, 64'(bus.flags), 64'(e.fl));
        check({tag, "_skipped"}, 64'(bus.skipped), 64'(e.skip));
        o_res = bus.result; o_fl = bus.flags; o_skip = bus.skipped;
        m_flags = e.fl;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            drive_junk(1'b1);
            check({tag, "_hold_result"}, 64'(bus.result), 64'(e.res));
            check({tag, "_hold_in_ready"}, 64'(bus.in_ready), 64'd0);
            check({tag, "_hold_out_valid"}, 64'(bus.out_valid), 64'd1);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        check({tag, "_retire_out_valid"}, 64'(bus.out_valid), 64'd0);
        check({tag, "_retire_in_ready"}, 64'(bus.in_ready), 64'd1);
    endtask

    initial begin
        logic [31:0] r;
        logic [3:0]  f;
        logic        s;
        n_checks = 0;
        n_errors = 0;
        m_flags  = 4'b0000;
        rst_n = 1'b0;
        drive_junk(1'b0);
        bus.out_ready = 1'b0;
        #1;
        check("reset_out_valid", 64'(bus.out_valid), 64'd0);
        check("reset_result", 64'(bus.result), 64'd0);
        check("reset_flags", 64'(bus.flags), 64'd0);
        check("reset_skipped", 64'(bus.skipped), 64'd0);
        check("reset_in_ready", 64'(bus.in_ready), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("post_reset_in_ready", 64'(bus.in_ready), 64'd1);

        run_op("add_ovf", 4'd0, 4'd0, 3'd0, 1'b1, 16'h0, 32'h7FFF_FFFF, 32'h1, 0, r, f, s);
        check("add_ovf_const_res", 64'(r), 64'h8000_0000);
        check("add_ovf_const_flags", 64'(f), 64'b1001);

        run_op("sub_eq", 4'd1, 4'd0, 3'd0, 1'b1, 16'h0, 32'd5, 32'd5, 0, r, f, s);
        check("sub_eq_const_flags", 64'(f), 64'b0110);
        run_op("movn_eq", 4'd6, 4'd1, 3'd0, 1'b0, 16'h1234, 32'h0, 32'h0, 0, r, f, s);
        check("movn_eq_const_res", 64'(r), 64'h0000_1234);
        check("movn_eq_const_skip", 64'(s), 64'd0);
        run_op("movn_gt", 4'd6, 4'd2, 3'd0, 1'b0, 16'h1234, 32'h0, 32'h0, 0, r, f, s);
        check("movn_gt_const_res", 64'(r), 64'h0);
        check("movn_gt_const_skip", 64'(s), 64'd1);
        check("movn_gt_const_flags", 64'(f), 64'b0110);

        run_op("mul_tp", 4'd2, 4'd0, 3'd0, 1'b0, 16'h0, 32'h0000_FFFF, 32'h0001_0001, 0, r, f, s);
`ifdef SEQ_ALU_MUL_EN
        check("mul_tp_const_res", 64'(r), 64'hFFFF_FFFF);
`else
        check("mul_tp_const_res", 64'(r), 64'h0);
`endif

        run_op("rot4", 4'd0, 4'd0, 3'b011, 1'b0, 16'h0020, 32'h0, 32'h0000_000F, 0, r, f, s);
        check("rot4_const_res", 64'(r), 64'hF000_0000);
        run_op("rot0", 4'd0, 4'd0, 3'b011, 1'b0, 16'h0000, 32'h0, 32'h0000_000F, 0, r, f, s);
        check("rot0_const_res", 64'(r), 64'h0000_000F);

        run_op("hold10", 4'd5, 4'd0, 3'd0, 1'b0, 16'h0, 32'hA5A5_0000, 32'h0000_5A5A, 10, r, f, s);

        run_op("pre_abort", 4'd1, 4'd0, 3'd0, 1'b1, 16'h0, 32'd5, 32'd5, 0, r, f, s);
        bus.in_valid = 1'b1; bus.opcode = 4'd2; bus.cond = 4'd0; bus.srcontrol = 3'd0;
        bus.sbit = 1'b1; bus.imvalue = 16'h0; bus.in1 = 32'h1234_5678; bus.in2 = 32'h9;
        @(posedge clk);
        bus.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_out_valid", 64'(bus.out_valid), 64'd0);
        check("abort_flags", 64'(bus.flags), 64'd0);
        check("abort_in_ready", 64'(bus.in_ready), 64'd0);
        check("abort_result", 64'(bus.result), 64'd0);
        m_flags = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op("post_abort", 4'd0, 4'd0, 3'd0, 1'b1, 16'h0, 32'hFFFF_FFFF, 32'h1, 0, r, f, s);
        check("post_abort_const_flags", 64'(f), 64'b0110);

        for (int i = 0; i < 200; i++) begin
            run_op($sformatf("rnd%0d", i),
                   4'($urandom_range(0, 15)),
                   ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 15)) : 4'd0,
                   3'($urandom_range(0, 7)),
                   1'($urandom_range(0, 1)),
                   16'($urandom),
                   pick(), pick(),
                   int'($urandom_range(0, 3)),
                   r, f, s);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
